lsu_byte: RTL and testbench
===========================

LSU_BYTE -- requirements
Module: lsu_byte

Interface
REQ-001 SHALL expose parameter BUS_WAIT_MAX, default 15; bus_ack timeout in cycles per byte beat.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_op  input  8  active-low one-hot from decoder: [7]lb [6]lh [5]lw [4]lbu [3]lhu [2]sb [1]sh [0]sw; all-ones = no access.
REQ-005 SHALL have port addr  input  32  effective byte address (ALU result), held stable while stall low.
REQ-006 SHALL have port wdata  input  32  store data (rs2), held stable while stall low.
REQ-007 SHALL have port stall  output  1  active low; freezes upstream pipeline.
REQ-008 SHALL have port done  output  1  active-low single-cycle retire pulse.
REQ-009 SHALL have port fault  output  1  active-low single-cycle pulse for misaligned access or bus timeout.
REQ-010 SHALL have port rdata  output  32  extended load result, valid while done low.
REQ-011 SHALL have port bus_addr  output  32  byte address on the 8-bit memory bus.
REQ-012 SHALL have port bus_wdata  output  8  write byte.
REQ-013 SHALL have port bus_rdata  input  8  read byte.
REQ-014 SHALL have port bus_oe  output  1  active-low read strobe.
REQ-015 SHALL have port bus_we  output  1  active-low write strobe.
REQ-016 SHALL have port bus_ack  input  1  active-high beat-complete from memory.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, DONE, FAULT.
REQ-018 IDLE: any mem_op bit low -> FAULT if misaligned, else ACCESS with beat counter = 0.
REQ-019 Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0; byte ops never misaligned.
REQ-020 If more than one mem_op bit is low, the highest-numbered low bit SHALL win.
REQ-021 Beat count: byte ops 1, half ops 2, word ops 4; little-endian, beat k uses bus_addr = addr+k, bus_wdata = wdata[8k+7:8k].
REQ-022 ACCESS: exactly one of bus_oe/bus_we low each cycle; strobe held until bus_ack sampled high; the read byte is captured on that edge and the counter increments.
REQ-023 Minimum latency: N beats + 1 DONE cycle (bus_ack tied high -> lw retires on cycle 5 after acceptance).
REQ-024 After the last beat -> DONE for one cycle: done low, strobes high, then IDLE.
REQ-025 rdata in DONE: lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw raw; stores give 0.
REQ-026 If bus_ack stays low for BUS_WAIT_MAX consecutive cycles in a beat -> FAULT; wait counter clears each beat.
REQ-027 FAULT: one cycle, fault low, no strobes, rdata 0, then IDLE; no partial-store rollback.
REQ-028 stall SHALL be low when mem_op != all-ones and state is IDLE or ACCESS; high in DONE and FAULT.
REQ-029 A request is accepted only in IDLE; mem_op changes during ACCESS are ignored; the IDLE cycle after DONE/FAULT samples the next instruction.
REQ-030 Strobes SHALL be glitch-free registered outputs; bus_addr/bus_wdata stable for the whole beat.

Reset
REQ-031 On rst low, asynchronously: state IDLE, counters 0, bus_oe=bus_we=1, done=fault=1, rdata=0, bus_addr=0, bus_wdata=0.
REQ-032 Reset mid-ACCESS SHALL deassert strobes immediately; the interrupted access is abandoned.
REQ-033 stall SHALL be high while rst is low.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding, the mem_op bit indices, and the beat-count constants.
REQ-035 Sign/zero extension SHALL be one combinational sub-module _ext32 (in: 32-bit assembled word, size, unsigned flag).

Verification
REQ-036 lw at 0x100, bus_ack high, memory bytes 11 22 33 44 -> 4 oe beats at 0x100..0x103, done low on cycle 5, rdata=0x44332211.
REQ-037 lb at 0x203 reading 0x80 -> rdata=0xFFFFFF80; lbu same address -> rdata=0x00000080.
REQ-038 sh at 0x10 wdata=0xDEADBEEF -> two we beats: 0x10<-0xEF, 0x11<-0xBE; rdata=0.
REQ-039 lw at 0x102 -> no strobes, fault low 1 cycle, stall high that cycle.
REQ-040 lhu with bus_ack low for 3 cycles per beat -> each strobe held 4 cycles, done after 9 cycles; bus_ack never high -> fault after BUS_WAIT_MAX.
REQ-041 rst pulsed low during beat 2 of sw -> strobes high same cycle, FSM IDLE, stall high.

Source files
------------

// File: rtl/lsu_byte_pkg.sv
// Shared definitions for the byte-serial load/store unit: FSM encoding,
// mem_op bit positions, access sizes and beat counts.
package lsu_byte_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2,
    StFault  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2
  } size_e;

  // Bit positions inside the active-low one-hot mem_op vector.
  localparam int unsigned OpLb  = 7;
  localparam int unsigned OpLh  = 6;
  localparam int unsigned OpLw  = 5;
  localparam int unsigned OpLbu = 4;
  localparam int unsigned OpLhu = 3;
  localparam int unsigned OpSb  = 2;
  localparam int unsigned OpSh  = 1;
  localparam int unsigned OpSw  = 0;

  localparam logic [2:0] BeatsByte = 3'd1;
  localparam logic [2:0] BeatsHalf = 3'd2;
  localparam logic [2:0] BeatsWord = 3'd4;

  typedef struct packed {
    logic  store;
    logic  uns;
    size_e size;
  } op_t;

  // Highest-numbered low bit wins when several are asserted.
  function automatic op_t decode_op(input logic [7:0] mem_op);
    op_t op;
    op.store = 1'b0;
    op.uns   = 1'b0;
    op.size  = SzByte;
    if (!mem_op[OpLb]) begin
      op.size = SzByte;
    end else if (!mem_op[OpLh]) begin
      op.size = SzHalf;
    end else if (!mem_op[OpLw]) begin
      op.size = SzWord;
    end else if (!mem_op[OpLbu]) begin
      op.size = SzByte;
      op.uns  = 1'b1;
    end else if (!mem_op[OpLhu]) begin
      op.size = SzHalf;
      op.uns  = 1'b1;
    end else if (!mem_op[OpSb]) begin
      op.size  = SzByte;
      op.store = 1'b1;
    end else if (!mem_op[OpSh]) begin
      op.size  = SzHalf;
      op.store = 1'b1;
    end else if (!mem_op[OpSw]) begin
      op.size  = SzWord;
      op.store = 1'b1;
    end
    return op;
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
    logic mis;
    unique case (size)
      SzHalf:  mis = addr_lo[0];
      SzWord:  mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [2:0] beat_count(input size_e size);
    logic [2:0] n;
    unique case (size)
      SzHalf:  n = BeatsHalf;
      SzWord:  n = BeatsWord;
      default: n = BeatsByte;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_byte_ext32.sv
// Sign/zero extension of the assembled little-endian load word to 32 bits.
module lsu_byte_ext32
  import lsu_byte_pkg::*;
(
  input  logic [31:0] word,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] result
);

  always_comb begin
    unique case (size)
      SzByte:  result = uns ? {24'h000000, word[7:0]} : {{24{word[7]}}, word[7:0]};
      SzHalf:  result = uns ? {16'h0000, word[15:0]} : {{16{word[15]}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_byte.sv
// Load/store unit that serialises byte/half/word accesses onto an 8-bit
// handshaked memory bus, one byte per beat, little-endian.
module lsu_byte
  import lsu_byte_pkg::*;
#(
  parameter int unsigned BUS_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        bus_oe,
  output logic        bus_we,
  input  logic        bus_ack
);

  localparam int unsigned WaitW = (BUS_WAIT_MAX < 2) ? 1 : $clog2(BUS_WAIT_MAX);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(BUS_WAIT_MAX - 1);

  state_e state_q, state_d;
  op_t    op_in, op_q, op_d;

  logic             req_valid, req_misaligned;
  logic [31:0]      base_q, base_d;
  logic [31:0]      wbuf_q, wbuf_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      word_asm, ext_word;
  logic [1:0]       beat_q, beat_d, beat_nxt, last_beat;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             beat_last, timeout;

  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] baddr_q, baddr_d;
  logic [7:0]  bwdata_q, bwdata_d;

  assign op_in          = decode_op(mem_op);
  assign req_valid      = (mem_op != 8'hFF);
  assign req_misaligned = misaligned(op_in.size, addr[1:0]);
  assign last_beat      = 2'(beat_count(op_q.size) - 3'd1);
  assign beat_last      = (beat_q == last_beat);
  assign beat_nxt       = beat_q + 2'd1;
  assign timeout        = !bus_ack && (wait_q == WaitLast);

  // Merge the byte arriving this cycle so the final beat reaches rdata without delay.
  always_comb begin
    word_asm = word_q;
    word_asm[{beat_q, 3'b000} +: 8] = bus_rdata;
  end

  lsu_byte_ext32 u_ext32 (
    .word   (word_asm),
    .size   (op_q.size),
    .uns    (op_q.uns),
    .result (ext_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = req_misaligned ? StFault : StAccess;
        end
      end
      StAccess: begin
        if (bus_ack && beat_last) begin
          state_d = StDone;
        end else if (timeout) begin
          state_d = StFault;
        end
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    base_d   = base_q;
    wbuf_d   = wbuf_q;
    word_d   = word_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    baddr_d  = baddr_q;
    bwdata_d = bwdata_q;
    rdata_d  = 32'h0;

    if (state_q == StIdle && req_valid) begin
      op_d   = op_in;
      base_d = addr;
      wbuf_d = wdata;
      word_d = 32'h0;
      beat_d = 2'd0;
      wait_d = '0;
      if (!req_misaligned) begin
        baddr_d  = addr;
        bwdata_d = wdata[7:0];
      end
    end else if (state_q == StAccess) begin
      if (bus_ack) begin
        word_d = word_asm;
        wait_d = '0;
        if (!beat_last) begin
          beat_d   = beat_nxt;
          baddr_d  = base_q + 32'(beat_nxt);
          bwdata_d = wbuf_q[{beat_nxt, 3'b000} +: 8];
        end
      end else if (!timeout) begin
        wait_d = wait_q + 1'b1;
      end
    end

    // Outputs are registered from the next state so they never glitch.
    oe_d    = !(state_d == StAccess && !op_d.store);
    we_d    = !(state_d == StAccess && op_d.store);
    done_d  = !(state_d == StDone);
    fault_d = !(state_d == StFault);
    if (state_d == StDone && !op_q.store) begin
      rdata_d = ext_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '{store: 1'b0, uns: 1'b0, size: SzByte};
      base_q   <= 32'h0;
      wbuf_q   <= 32'h0;
      word_q   <= 32'h0;
      beat_q   <= 2'd0;
      wait_q   <= '0;
      done_q   <= 1'b1;
      fault_q  <= 1'b1;
      oe_q     <= 1'b1;
      we_q     <= 1'b1;
      rdata_q  <= 32'h0;
      baddr_q  <= 32'h0;
      bwdata_q <= 8'h0;
    end else begin
      op_q     <= op_d;
      base_q   <= base_d;
      wbuf_q   <= wbuf_d;
      word_q   <= word_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      baddr_q  <= baddr_d;
      bwdata_q <= bwdata_d;
    end
  end

  assign stall     = !(rst && req_valid && (state_q == StIdle || state_q == StAccess));
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign bus_addr  = baddr_q;
  assign bus_wdata = bwdata_q;
  assign bus_oe    = oe_q;
  assign bus_we    = we_q;

endmodule

// File: tb/tb_lsu_byte.sv
// Self-checking bench for lsu_byte: directed scenarios plus randomized
// accesses against a byte-memory reference model with variable ack latency.
module tb_lsu_byte;

  localparam int unsigned WaitMax = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdata, bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = 8'h00;
  logic        bus_oe, bus_we;
  logic        bus_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [int unsigned];
  int          ack_delay = 0;
  int          lat_cnt = 0;
  logic [31:0] beat_addr[$];
  logic [7:0]  beat_data[$];
  logic        beat_we[$];

  lsu_byte #(.BUS_WAIT_MAX(WaitMax)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_op    (mem_op),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .fault     (fault),
    .rdata     (rdata),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_oe    (bus_oe),
    .bus_we    (bus_we),
    .bus_ack   (bus_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
  endfunction

  // Memory responder: acks after ack_delay strobed cycles of each beat.
  always @(negedge clk) begin
    if (!bus_oe || !bus_we) begin
      bus_ack   = (lat_cnt >= ack_delay);
      bus_rdata = mem_rd(bus_addr);
    end else begin
      bus_ack = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst && (!bus_oe || !bus_we)) begin
      if (bus_ack) begin
        lat_cnt = 0;
        beat_addr.push_back(bus_addr);
        beat_we.push_back(!bus_we);
        beat_data.push_back(bus_wdata);
        if (!bus_we) mem[bus_addr] = bus_wdata;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: decode by highest low bit, then plain arithmetic on memory bytes.
  task automatic model(input logic [7:0] op_vec, input logic [31:0] a, output int bytes,
                       output bit st, output bit sgn, output bit mis);
    int hi = -1;
    for (int i = 7; i >= 0; i--) if (!op_vec[i] && hi < 0) hi = i;
    st = (hi <= 2);
    sgn = (hi == 7 || hi == 6);
    case (hi)
      7, 4, 2: bytes = 1;
      6, 3, 1: bytes = 2;
      default: bytes = 4;
    endcase
    mis = (a % bytes) != 0;
  endtask

  function automatic logic [31:0] load_value(input logic [31:0] a, input int bytes, input bit sgn);
    longint v = 0;
    for (int k = 0; k < bytes; k++) v += longint'(mem_rd(a + k)) << (8 * k);
    if (sgn && v >= (longint'(1) << (8 * bytes - 1))) v -= (longint'(1) << (8 * bytes));
    return 32'(v);
  endfunction

  task automatic run_op(input logic [7:0] op_vec, input logic [31:0] a, input logic [31:0] wd,
                        input int delay, output logic [31:0] got);
    int bytes, cyc, exp_cyc, exp_beats;
    bit st, sgn, mis, exp_fault, fin, strobe_bad, stall_bad;
    logic [31:0] exp_r, end_rdata;
    logic end_stall, end_done, end_fault;
    logic [1:0] end_strobes;
    model(op_vec, a, bytes, st, sgn, mis);
    exp_fault = mis || (delay >= int'(WaitMax));
    exp_r     = (exp_fault || st) ? 32'h0 : load_value(a, bytes, sgn);
    exp_cyc   = mis ? 1 : (exp_fault ? int'(WaitMax) + 1 : bytes * (delay + 1) + 1);
    exp_beats = exp_fault ? 0 : bytes;
    beat_addr.delete(); beat_we.delete(); beat_data.delete();
    ack_delay = delay;
    @(negedge clk);
    mem_op = op_vec; addr = a; wdata = wd;
    #1 check("stall_request", stall, 0);
    cyc = 0; fin = 0; strobe_bad = 0; stall_bad = 0;
    end_rdata = 'x; end_stall = 'x; end_done = 'x; end_fault = 'x; end_strobes = 'x;
    while (!fin && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!done || !fault) begin
        fin = 1;
        end_rdata = rdata; end_stall = stall; end_done = done; end_fault = fault;
        end_strobes = {bus_oe, bus_we};
        mem_op = 8'hFF;
      end else begin
        if ((bus_oe ^ bus_we) !== 1'b1 || bus_we !== !st) strobe_bad = 1;
        if (stall !== 1'b0) stall_bad = 1;
      end
    end
    check("completed", 32'(fin), 1);
    check("latency", cyc, exp_cyc);
    check("fault_pulse", 32'(end_fault), 32'(!exp_fault));
    check("done_pulse", 32'(end_done), 32'(exp_fault));
    check("rdata", end_rdata, exp_r);
    check("stall_end", 32'(end_stall), 1);
    check("strobes_end", 32'(end_strobes), 32'h3);
    check("strobe_access", 32'(strobe_bad), 0);
    check("stall_access", 32'(stall_bad), 0);
    check("beat_count", beat_addr.size(), exp_beats);
    for (int k = 0; k < beat_addr.size() && k < exp_beats; k++) begin
      check("beat_addr", beat_addr[k], a + k);
      check("beat_dir", 32'(beat_we[k]), 32'(st));
      if (st) check("beat_wdata", 32'(beat_data[k]), 32'(wd[8*k +: 8]));
    end
    got = end_rdata;
    @(negedge clk);
    check("pulse_clear", 32'({done, fault}), 32'h3);
    check("stall_idle", 32'(stall), 1);
  endtask

  initial begin
    logic [31:0] got;
    logic [7:0]  op_vec;
    int          idx;
    rst = 1'b0; mem_op = 8'h7F; addr = 32'h0; wdata = 32'h0;
    #12;
    check("rst_oe", 32'(bus_oe), 1);
    check("rst_we", 32'(bus_we), 1);
    check("rst_done", 32'(done), 1);
    check("rst_fault", 32'(fault), 1);
    check("rst_rdata", rdata, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", 32'(bus_wdata), 0);
    check("rst_stall", 32'(stall), 1);
    @(negedge clk);
    mem_op = 8'hFF; rst = 1'b1;

    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    run_op(8'hDF, 32'h100, 32'h0, 0, got);
    check("lw_word", got, 32'h44332211);

    mem[32'h203] = 8'h80;
    run_op(8'h7F, 32'h203, 32'h0, 0, got);
    check("lb_sign", got, 32'hFFFFFF80);
    run_op(8'hEF, 32'h203, 32'h0, 0, got);
    check("lbu_zero", got, 32'h00000080);

    run_op(8'hFD, 32'h10, 32'hDEADBEEF, 0, got);
    check("sh_rdata", got, 0);
    check("sh_byte0", 32'(mem[32'h10]), 32'hEF);
    check("sh_byte1", 32'(mem[32'h11]), 32'hBE);

    run_op(8'hDF, 32'h102, 32'h0, 0, got);
    run_op(8'hF7, 32'h20, 32'h0, 3, got);
    run_op(8'hF7, 32'h22, 32'h0, 1000, got);
    run_op(8'h7E, 32'h203, 32'h0, 0, got);
    check("priority_lb", got, 32'hFFFFFF80);

    // Reset while the third beat of a word store is on the bus.
    beat_addr.delete(); beat_we.delete(); beat_data.delete();
    ack_delay = 0;
    @(negedge clk);
    mem_op = 8'hFE; addr = 32'h40; wdata = 32'h0A0B0C0D;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_we", 32'(bus_we), 1);
    check("rst_mid_oe", 32'(bus_oe), 1);
    check("rst_mid_stall", 32'(stall), 1);
    check("rst_mid_addr", bus_addr, 0);
    check("rst_mid_beats", beat_addr.size(), 2);
    mem_op = 8'hFF;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_strobes", 32'({bus_oe, bus_we}), 32'h3);
    check("post_rst_stall", 32'(stall), 1);
    run_op(8'hDF, 32'h40, 32'h0, 0, got);
    check("partial_store_kept", got, {mem_rd(32'h43), mem_rd(32'h42), 8'h0C, 8'h0D});

    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(7, 0);
      op_vec = ~(8'h01 << idx);
      op_vec = op_vec & ~(8'($urandom) & ((8'h01 << idx) - 8'h01));
      run_op(op_vec, $urandom_range(32'h3FF, 0), $urandom, $urandom_range(2, 0), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
